// File: rtl/multi_alarm.sv
// Multi-channel alarm clock: per-channel programmable alarm time, snooze, dismiss and
// ring auto-stop, driven by an external time-of-day source.
module multi_alarm #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60,
  localparam int unsigned CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      sec_in,
  input  logic [5:0]      min_in,
  input  logic [4:0]      hour_in,
  input  logic [N_CH-1:0] enable,
  input  logic [CW-1:0]   chan_sel,
  input  logic [1:0]      select,
  input  logic            increment,
  input  logic            snooze,
  input  logic            dismiss,
  output logic [5:0]      sec_out,
  output logic [5:0]      min_out,
  output logic [4:0]      hour_out,
  output logic [N_CH-1:0] ring,
  output logic            out
);

  typedef enum logic [1:0] {StIdle, StArmed, StRinging, StSnoozed} state_e;

  localparam logic [5:0] SnzMin   = 6'(SNOOZE_MIN);
  localparam logic [7:0] RingLast = 8'(RING_SEC - 1);

  logic       inc_q, snz_q, dis_q;
  logic [2:0] hold_q;
  logic [5:0] sec_q;
  logic       inc_edge, snz_edge, dis_edge, sec_tick;

  logic [5:0] al_sec_q  [N_CH];
  logic [5:0] al_sec_d  [N_CH];
  logic [5:0] al_min_q  [N_CH];
  logic [5:0] al_min_d  [N_CH];
  logic [4:0] al_hour_q [N_CH];
  logic [4:0] al_hour_d [N_CH];
  logic [5:0] tg_sec_q  [N_CH];
  logic [5:0] tg_sec_d  [N_CH];
  logic [5:0] tg_min_q  [N_CH];
  logic [5:0] tg_min_d  [N_CH];
  logic [4:0] tg_hour_q [N_CH];
  logic [4:0] tg_hour_d [N_CH];
  logic [7:0] cnt_q     [N_CH];
  logic [7:0] cnt_d     [N_CH];
  state_e     state_q   [N_CH];
  state_e     state_d   [N_CH];

  logic [N_CH-1:0] guard_q, guard_d;
  logic [N_CH-1:0] ring_q, ring_d;
  logic [N_CH-1:0] sel, alarm_hit, snz_hit;

  // hold_q blocks an input that was already high during reset until it is seen low,
  // so a level held across reset never counts as a fresh edge.
  assign inc_edge = increment & ~inc_q & ~hold_q[0];
  assign snz_edge = snooze    & ~snz_q & ~hold_q[1];
  assign dis_edge = dismiss   & ~dis_q & ~hold_q[2];
  assign sec_tick = (sec_in != sec_q);

  for (genvar g = 0; g < N_CH; g++) begin : g_hit
    assign sel[g]       = (chan_sel == CW'(g));
    assign alarm_hit[g] = ({hour_in, min_in, sec_in} ==
                           {al_hour_q[g], al_min_q[g], al_sec_q[g]});
    assign snz_hit[g]   = ({hour_in, min_in, sec_in} ==
                           {tg_hour_q[g], tg_min_q[g], tg_sec_q[g]});
  end

  logic [6:0] snz_sum;
  logic [5:0] snz_min;
  logic [4:0] snz_hour;

  always_comb begin
    snz_sum  = {1'b0, min_in} + {1'b0, SnzMin};
    snz_min  = snz_sum[5:0];
    snz_hour = hour_in;
    if (snz_sum >= 7'd60) begin
      snz_min  = 6'(snz_sum - 7'd60);
      snz_hour = (hour_in >= 5'd23) ? 5'd0 : hour_in + 5'd1;
    end
  end

  always_comb begin
    guard_d = '0;
    ring_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      al_sec_d[i]  = al_sec_q[i];
      al_min_d[i]  = al_min_q[i];
      al_hour_d[i] = al_hour_q[i];
      tg_sec_d[i]  = tg_sec_q[i];
      tg_min_d[i]  = tg_min_q[i];
      tg_hour_d[i] = tg_hour_q[i];
      cnt_d[i]     = cnt_q[i];
      state_d[i]   = state_q[i];

      if (inc_edge && sel[i]) begin
        unique case (select)
          2'd0: al_sec_d[i]  = (al_sec_q[i]  >= 6'd59) ? 6'd0 : al_sec_q[i]  + 6'd1;
          2'd1: al_min_d[i]  = (al_min_q[i]  >= 6'd59) ? 6'd0 : al_min_q[i]  + 6'd1;
          2'd2: al_hour_d[i] = (al_hour_q[i] >= 5'd23) ? 5'd0 : al_hour_q[i] + 5'd1;
          2'd3: ;
        endcase
      end

      if (!enable[i]) begin
        state_d[i] = StIdle;
      end else begin
        unique case (state_q[i])
          StIdle: state_d[i] = StArmed;
          StArmed: begin
            if (alarm_hit[i] && (!guard_q[i] || sec_tick)) begin
              state_d[i] = StRinging;
              cnt_d[i]   = '0;
            end
          end
          StRinging: begin
            if (dis_edge && sel[i]) begin
              state_d[i] = StArmed;
            end else if (snz_edge && sel[i]) begin
              state_d[i]   = StSnoozed;
              tg_sec_d[i]  = sec_in;
              tg_min_d[i]  = snz_min;
              tg_hour_d[i] = snz_hour;
            end else if (sec_tick) begin
              if (cnt_q[i] == RingLast) state_d[i] = StArmed;
              else                      cnt_d[i]   = cnt_q[i] + 8'd1;
            end
          end
          StSnoozed: begin
            if (dis_edge && sel[i]) begin
              state_d[i] = StArmed;
            end else if (snz_hit[i]) begin
              state_d[i] = StRinging;
              cnt_d[i]   = '0;
            end
          end
        endcase
      end

      // Leaving RINGING blocks a re-match until the second moves on.
      guard_d[i] = (guard_q[i] & ~sec_tick) |
                   ((state_q[i] == StRinging) && (state_d[i] != StRinging));
      ring_d[i]  = (state_d[i] == StRinging);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inc_q   <= 1'b0;
      snz_q   <= 1'b0;
      dis_q   <= 1'b0;
      hold_q  <= {dismiss, snooze, increment};
      sec_q   <= '0;
      guard_q <= '0;
      ring_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        al_sec_q[i]  <= '0;
        al_min_q[i]  <= '0;
        al_hour_q[i] <= '0;
        tg_sec_q[i]  <= '0;
        tg_min_q[i]  <= '0;
        tg_hour_q[i] <= '0;
        cnt_q[i]     <= '0;
        state_q[i]   <= StIdle;
      end
    end else begin
      inc_q   <= increment;
      snz_q   <= snooze;
      dis_q   <= dismiss;
      hold_q  <= hold_q & {dismiss, snooze, increment};
      sec_q   <= sec_in;
      guard_q <= guard_d;
      ring_q  <= ring_d;
      for (int i = 0; i < N_CH; i++) begin
        al_sec_q[i]  <= al_sec_d[i];
        al_min_q[i]  <= al_min_d[i];
        al_hour_q[i] <= al_hour_d[i];
        tg_sec_q[i]  <= tg_sec_d[i];
        tg_min_q[i]  <= tg_min_d[i];
        tg_hour_q[i] <= tg_hour_d[i];
        cnt_q[i]     <= cnt_d[i];
        state_q[i]   <= state_d[i];
      end
    end
  end

  always_comb begin
    sec_out  = '0;
    min_out  = '0;
    hour_out = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel[i]) begin
        sec_out  = al_sec_q[i];
        min_out  = al_min_q[i];
        hour_out = al_hour_q[i];
      end
    end
  end

  assign ring = ring_q;
  assign out  = |ring_q;

endmodule
